// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: decoupled fetch PC + DEPTH-entry in-order instruction queue with redirect/flush.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_queue_unit #(
    parameter int ADDR_W = 32,
    parameter int INSTR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);
    localparam int PW = $clog2(DEPTH) + 1;
    // Stale responses can outnumber DEPTH after back-to-back redirects, so the drop counter has headroom.
    localparam int DW = PW + 2;

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [PW-1:0]      r_alloc, r_fill, r_head;
    logic [DW-1:0]      r_drop;
    logic [DEPTH-1:0]   r_filled;
    logic [ADDR_W-1:0]  r_pc [DEPTH];
    logic [INSTR_W-1:0] r_instr [DEPTH];

    logic [PW-1:0]      w_occ, w_pend;
    logic [PW-2:0]      w_aidx, w_fidx, w_hidx;
    logic               w_req_fire, w_out_valid, w_out_fire, w_rsp_keep;

    assign w_occ       = r_alloc - r_head;
    assign w_pend      = r_alloc - r_fill;
    assign w_aidx      = r_alloc[PW-2:0];
    assign w_fidx      = r_fill[PW-2:0];
    assign w_hidx      = r_head[PW-2:0];
    assign w_req_fire  = imem_req_valid && imem_req_ready;
    assign w_out_valid = r_filled[w_hidx] && (r_head != r_alloc);
    assign w_out_fire  = w_out_valid && out_ready;
    assign w_rsp_keep  = imem_rsp_valid && (r_drop == '0);

    assign imem_req_valid = !rst && (w_occ < PW'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign out_valid      = w_out_valid;
    assign out_pc         = w_out_valid ? r_pc[w_hidx] : '0;
    assign out_instr      = w_out_valid ? r_instr[w_hidx] : '0;

    always_ff @(posedge clk) begin
        if (w_req_fire) r_pc[w_aidx] <= r_fetch_pc;
        if (w_rsp_keep) r_instr[w_fidx] <= imem_rsp_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_alloc    <= '0;
            r_fill     <= '0;
            r_head     <= '0;
            r_drop     <= '0;
            r_filled   <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            r_fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            r_alloc    <= '0;
            r_fill     <= '0;
            r_head     <= '0;
            r_drop     <= r_drop + DW'(w_pend) + DW'(w_req_fire) - DW'(imem_rsp_valid);
        end else begin
            if (w_req_fire) begin
                r_filled[w_aidx] <= 1'b0;
                r_alloc          <= r_alloc + 1'b1;
                r_fetch_pc       <= r_fetch_pc + ADDR_W'(4);
            end
            if (imem_rsp_valid && r_drop != '0) r_drop <= r_drop - 1'b1;
            if (w_rsp_keep) begin
                r_filled[w_fidx] <= 1'b1;
                r_fill           <= r_fill + 1'b1;
            end
            if (w_out_fire) r_head <= r_head + 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (w_out_fire) perf_fetched <= perf_fetched + 1'b1;
            if (!w_out_valid && out_ready) perf_stall <= perf_stall + 1'b1;
        end
    end
`endif
endmodule
